// File: rtl/seg_display_pkg.sv
// Shared seven-segment definitions: bit positions within {dp,g,f,e,d,c,b,a}
// and the active-low glyph patterns for every hex nibble.
package seg_display_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Glyphs are {g,f,e,d,c,b,a}, a 0 lights the segment
    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h10;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
    import seg_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_HEX_0;
        case (nibble)
            4'h0: seg_n = SEG_HEX_0;
            4'h1: seg_n = SEG_HEX_1;
            4'h2: seg_n = SEG_HEX_2;
            4'h3: seg_n = SEG_HEX_3;
            4'h4: seg_n = SEG_HEX_4;
            4'h5: seg_n = SEG_HEX_5;
            4'h6: seg_n = SEG_HEX_6;
            4'h7: seg_n = SEG_HEX_7;
            4'h8: seg_n = SEG_HEX_8;
            4'h9: seg_n = SEG_HEX_9;
            4'hA: seg_n = SEG_HEX_A;
            4'hB: seg_n = SEG_HEX_B;
            4'hC: seg_n = SEG_HEX_C;
            4'hD: seg_n = SEG_HEX_D;
            4'hE: seg_n = SEG_HEX_E;
            default: seg_n = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with frame-shadowed content, PWM dimming,
// per-digit blink and leading-zero blanking; AN/BCD are registered.
module seg_scan_driver
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 5000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    on,
    input  logic [4*NUM_DIGITS-1:0] number,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic [7:0]              BCD,
    output logic                    frame_done
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              phase_q, phase_d;
    logic                    blink_on_q, blink_on_d;
    logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
    logic [4*NUM_DIGITS-1:0] num_sh_q, num_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blk_sh_q, blk_sh_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              bcd_q, bcd_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_tc, wrap;
    logic [IDX_W-1:0]        pos;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blk, cur_lz, seen_nz;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    blink_hide, lit;
    logic [6:0]              seg_n;

    always_comb begin
        slot_tc      = (slot_q == SLOT_LAST);
        wrap         = slot_tc && (idx_q == IDX_LAST);
        slot_d       = slot_tc ? '0 : slot_q + SLOT_W'(1);
        idx_d        = idx_q;
        phase_d      = phase_q + 4'd1;
        num_sh_d     = num_sh_q;
        dp_sh_d      = dp_sh_q;
        blk_sh_d     = blk_sh_q;
        blink_on_d   = blink_on_q;
        blink_cnt_d  = blink_cnt_q;
        frame_done_d = wrap;
        if (slot_tc) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
        // The frame boundary is the only point where new content is captured
        if (wrap) begin
            num_sh_d = number;
            dp_sh_d  = dp;
            blk_sh_d = blink_en;
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end
    end

    // Scan index k addresses nibble NUM_DIGITS-1-k, so index 0 is the leftmost digit
    always_comb begin
        pos     = IDX_LAST - idx_q;
        cur_nib = '0;
        cur_dp  = 1'b0;
        cur_blk = 1'b0;
        cur_lz  = 1'b0;
        seen_nz = 1'b0;
        an_sel  = '1;
        for (int p = NUM_DIGITS - 1; p >= 0; p--) begin
            seen_nz = seen_nz | (num_sh_q[4*p +: 4] != 4'd0);
            if (pos == IDX_W'(p)) begin
                cur_nib   = num_sh_q[4*p +: 4];
                cur_dp    = dp_sh_q[p];
                cur_blk   = blk_sh_q[p];
                cur_lz    = (p != 0) && !seen_nz;
                an_sel[p] = 1'b0;
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nib),
        .seg_n  (seg_n)
    );

    always_comb begin
        blink_hide = cur_blk && !blink_on_q;
        lit        = on && (phase_q <= brightness);
        an_d       = '1;
        bcd_d      = SEG_OFF;
        if (lit) begin
            an_d          = an_sel;
            bcd_d[SEG_DP] = ~(cur_dp && !blink_hide);
            if (!(blank_lz && cur_lz) && !blink_hide) begin
                bcd_d[SEG_G:SEG_A] = seg_n;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q       <= '0;
            idx_q        <= '0;
            phase_q      <= '0;
            blink_on_q   <= 1'b1;
            blink_cnt_q  <= '0;
            num_sh_q     <= '0;
            dp_sh_q      <= '0;
            blk_sh_q     <= '0;
            an_q         <= '1;
            bcd_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            blink_on_q   <= blink_on_d;
            blink_cnt_q  <= blink_cnt_d;
            num_sh_q     <= num_sh_d;
            dp_sh_q      <= dp_sh_d;
            blk_sh_q     <= blk_sh_d;
            an_q         <= an_d;
            bcd_q        <= bcd_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign AN         = an_q;
    assign BCD        = bcd_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 5000, clocks per digit slot; legal range >= 2.
REQ-003 Parameter BLINK_FRAMES, default 64, full scan frames per blink half-period; legal range >= 1.
REQ-004 clk  input  1  single clock; all state rises on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 on  input  1  display enable; 0 blanks all digits.
REQ-007 number  input  4*NUM_DIGITS  hex nibbles; the top nibble is the leftmost digit.
REQ-008 dp  input  NUM_DIGITS  per-digit decimal point; bit i belongs to nibble i.
REQ-009 blink_en  input  NUM_DIGITS  per-digit blink enable; bit i belongs to nibble i.
REQ-010 blank_lz  input  1  leading-zero blanking enable.
REQ-011 brightness  input  4  PWM duty level; 15 = full on.
REQ-012 AN  output  NUM_DIGITS  digit anodes, active-low.
REQ-013 BCD  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-014 frame_done  output  1  one-cycle pulse when a full scan frame completes.

Function
REQ-015 The slot counter SHALL count 0..REFRESH_DIV-1; at the terminal count it SHALL return to 0 and advance the digit index.
REQ-016 The digit index SHALL count 0..NUM_DIGITS-1 and wrap to 0; index k selects nibble NUM_DIGITS-1-k and drives AN[NUM_DIGITS-1-k] low.
REQ-017 On an index wrap from NUM_DIGITS-1 to 0, the block SHALL load number, dp and blink_en into shadow registers and pulse frame_done for exactly one cycle.
REQ-018 Display content SHALL come only from the shadow registers, so no frame mixes two input values.
REQ-019 AN and BCD SHALL be registered, with a latency of exactly one clk from an index change.
REQ-020 A free-running 4-bit PWM phase counter SHALL increment every clk; the selected digit is lit only while phase <= brightness.
REQ-021 When PWM gates a digit off, AN SHALL be all ones and BCD SHALL be 8'hFF.
REQ-022 The blink phase SHALL toggle every BLINK_FRAMES frame_done pulses.
REQ-023 While the blink phase is off, digits with their shadow blink_en bit set SHALL show segments and dp off, with their anode still driven.
REQ-024 With blank_lz=1, zero nibbles from the leftmost digit up to the first nonzero nibble SHALL show segments off; dp still follows the dp bit.
REQ-025 Leading-zero blanking SHALL never blank the rightmost digit.
REQ-026 With on=0, the registered outputs SHALL show AN all ones and BCD 8'hFF; all counters and shadow loads SHALL keep running.
REQ-027 Nibble decode SHALL be full hex: 0-9 and A-F (A,b,C,d,E,F patterns).

Reset
REQ-028 Asserting reset SHALL immediately set: slot counter 0, index 0, PWM phase 0, blink phase on, blink frame count 0, shadows 0, AN all ones, BCD 8'hFF, frame_done 0.
REQ-029 Reset asserted mid-slot SHALL abort the slot; after deassertion, scanning restarts at index 0 with a full REFRESH_DIV slot.

Structure
REQ-030 Shared package seg_display_pkg SHALL hold the 16 active-low segment-pattern constants, the SEG_OFF (8'hFF) constant, and the segment bit-order definitions.
REQ-031 Nibble-to-segment decode SHALL be a combinational sub-module named hex_to_seg7, instantiated once.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, brightness=15, on=1 unless stated)
REQ-032 Scan order: number=16'h12AF -> AN sequence 0111,1011,1101,1110, each held 4 clks; BCD shows 1,2,A,F; frame_done pulses every 16 clks.
REQ-033 Tear-free update: change number from 16'h1234 to 16'h5678 mid-frame -> current frame completes showing 1234; 5678 appears from the next frame.
REQ-034 Leading-zero blanking: blank_lz=1, number=16'h0030, dp=4'b0100 -> digit 0 shows 8'hFF; digit 1 shows dp only; digits 2 and 3 show 3 and 0. With number=0, digits 0-2 are blank and digit 3 shows 0.
REQ-035 Brightness/on: brightness=3 -> the anode is low for 4 of every 16 clks. on=0 -> AN=4'b1111 and BCD=8'hFF, with frame_done still pulsing.
REQ-036 Blink/reset: blink_en=4'b0001 -> the rightmost digit is off for 2 frames, then on for 2 frames. Asserting reset mid-slot -> outputs reach reset values immediately; after release, the first AN low is 0111.
